// File: rtl/rv_arb_pkg.sv
// rtl/rv_arb_pkg.sv - shared types and helpers for the round-robin stream arbiter
package rv_arb_pkg;

   typedef enum logic {
      IDLE   = 1'b0,
      LOCKED = 1'b1
   } arb_state_t;

   // Index width for n requesters; a single requester still needs one bit.
   function automatic int clog2_min1(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rv_rr_pick.sv
// rtl/rv_rr_pick.sv - round-robin winner search starting just after rr_ptr
module rv_rr_pick
   import rv_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int SRC_W   = 2
)(
   input  logic [NUM_REQ-1:0] valid,
   input  logic [SRC_W-1:0]   rr_ptr,
   output logic               any_valid,
   output logic [SRC_W-1:0]   winner
);

   int               idx;
   logic [SRC_W-1:0] idx_s;

   // The first hit in the rotated order wins; later hits are masked by any_valid.
   always_comb begin
      any_valid = 1'b0;
      winner    = '0;
      idx       = 0;
      idx_s     = '0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx   = (int'(rr_ptr) + k) % NUM_REQ;
         idx_s = SRC_W'(idx);
         if (!any_valid && valid[idx_s]) begin
            any_valid = 1'b1;
            winner    = idx_s;
         end
      end
   end

endmodule

// File: rtl/rv_stream_arbiter.sv
// rtl/rv_stream_arbiter.sv - N-to-1 ready/valid arbiter, packet-granular round robin,
// registered output stage
module rv_stream_arbiter
   import rv_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8,
   parameter int SRC_W   = 2
)(
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ-1:0]          req_last,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic [DATA_W-1:0]           down_data,
   output logic                        down_valid,
   output logic                        down_last,
   output logic [SRC_W-1:0]            down_src,
   input  logic                        down_ready
);

   if (SRC_W != clog2_min1(NUM_REQ) || NUM_REQ < 2 || NUM_REQ > 16) begin : g_param_check
      $error("rv_stream_arbiter: NUM_REQ must be 2..16 and SRC_W must equal clog2_min1(NUM_REQ)");
   end

   arb_state_t       state_q, state_d;
   logic [SRC_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [SRC_W-1:0] owner_q, owner_d;

   logic             any_valid;
   logic [SRC_W-1:0] winner;
   logic [SRC_W-1:0] grant_idx;
   logic             grant_en;
   logic             can_load;
   logic             accept;
   logic [DATA_W-1:0] sel_data;
   logic             sel_last;

   rv_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .SRC_W   (SRC_W)
   ) u_pick (
      .valid     (req_valid),
      .rr_ptr    (rr_ptr_q),
      .any_valid (any_valid),
      .winner    (winner)
   );

   assign can_load = !down_valid || down_ready;

   // In LOCKED the owner is granted even while its valid is low, so the lock survives gaps.
   always_comb begin
      grant_idx = (state_q == LOCKED) ? owner_q : winner;
      grant_en  = (state_q == LOCKED) ? 1'b1 : any_valid;
      accept    = grant_en && can_load && req_valid[grant_idx];
      sel_data  = req_data[int'(grant_idx)*DATA_W +: DATA_W];
      sel_last  = req_last[grant_idx];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         rr_ptr_q <= SRC_W'(NUM_REQ - 1);
         owner_q  <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      rr_ptr_d = rr_ptr_q;
      owner_d  = owner_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (sel_last) begin
                  rr_ptr_d = winner;
               end else begin
                  state_d = LOCKED;
                  owner_d = winner;
               end
            end
         end
         LOCKED: begin
            if (accept && sel_last) begin
               state_d  = IDLE;
               rr_ptr_d = owner_q;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      req_ready = '0;
      if (grant_en && can_load) begin
         req_ready[grant_idx] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         down_valid <= 1'b0;
         down_data  <= '0;
         down_last  <= 1'b0;
         down_src   <= '0;
      end else if (accept) begin
         down_valid <= 1'b1;
         down_data  <= sel_data;
         down_last  <= sel_last;
         down_src   <= grant_idx;
      end else if (down_ready) begin
         down_valid <= 1'b0;
      end
   end

endmodule

// File: doc/rv_stream_arbiter.md
Name: rv_stream_arbiter

Overview:
N-to-1 ready/valid arbiter that shares one downstream ready/valid channel between NUM_REQ upstream requesters.
- Arbitration is round-robin at packet granularity: a granted requester keeps the channel until its last beat is accepted.
- Output is registered, one pipeline stage.
- Sits in front of the ready_valid_proxy datapath so that several producers can feed it.

Parameters:
NUM_REQ, 4, number of requesters (2..16)
DATA_W, 8, data width per beat
SRC_W, 2, width of source index; must equal max(1, ceil(log2(NUM_REQ)))

Ports:
clk  in  1  clock, all state updates on rising edge
rst_n  in  1  reset
req_data  in  NUM_REQ*DATA_W  requester data, requester i at bits [i*DATA_W +: DATA_W]
req_valid  in  NUM_REQ  per-requester valid
req_last  in  NUM_REQ  per-requester end-of-packet flag, qualified by req_valid
req_ready  out  NUM_REQ  per-requester ready
down_data  out  DATA_W  registered output data
down_valid  out  1  registered output valid
down_last  out  1  registered end-of-packet flag
down_src  out  SRC_W  index of the requester that produced the current output beat
down_ready  in  1  downstream ready

Interface decision: one clock, clk; reset rst_n is asynchronous and active-low.

Behaviour:
Reset:
- rst_n low forces, immediately: down_valid=0, down_data=0, down_last=0, down_src=0, state=IDLE, rr_ptr=NUM_REQ-1, owner=0.
- The rr_ptr value gives requester 0 first priority after reset.

Output stage:
- can_load = !down_valid || down_ready.
- A beat from requester i is accepted when req_valid[i] && req_ready[i].
- On accept: down_data/down_last/down_src load that beat and down_valid=1.
- Else if down_ready: down_valid=0, data/last/src hold.
- Else: all outputs hold, stable under backpressure.
- Throughput is 1 beat/cycle when down_ready stays high; latency is 1 cycle from accept to down_valid.

States:
- IDLE:
  - winner = first i with req_valid[i], searching rr_ptr+1, rr_ptr+2, ... modulo NUM_REQ.
  - req_ready[winner] = can_load; all other ready bits are 0.
  - If no requester is valid, all ready bits are 0.
  - On accept with req_last[winner]=1: stay IDLE and set rr_ptr=winner.
  - On accept with req_last=0: go to LOCKED and set owner=winner.
- LOCKED:
  - req_ready[owner] = can_load; all others are 0.
  - Other requesters' valids are ignored.
  - On accept of the owner's beat with req_last=1: go to IDLE and set rr_ptr=owner.
  - The owner may drop valid mid-packet; the lock is kept.

Combinational path and protocol rules:
- req_ready depends combinationally on down_ready and req_valid. No combinational path from req_data to any ready signal.
- A requester may not withdraw valid before its beat is accepted (protocol rule; not checked in RTL).
- down_valid, once high, stays high until down_ready.

Boundary conditions:
- A single-beat packet is granted and released in the same cycle. The next cycle can grant a different requester with no bubble.
- When all requesters are valid, grants rotate strictly 0,1,2,...,NUM_REQ-1,0.
- Reset asserted mid-packet (LOCKED) aborts the packet: the partial packet is not completed and the arbiter returns to IDLE.

Decomposition:
- Package rv_arb_pkg: state enum (IDLE, LOCKED), function clog2_min1 for SRC_W checking.
- One combinational sub-module rv_rr_pick: inputs valid vector and rr_ptr; outputs any_valid and winner index.
- The output register and FSM live in the top module.

Test Plan:
1. Reset values: hold rst_n low -> down_valid=0, down_data=0, down_src=0, all req_ready=0. Release rst_n with only req_valid[3]=1 -> req_ready[3]=1.
2. Single streamer: requester 1 sends beats 0..9, each single-beat, with down_ready=1 -> down_data 0..9 on 10 consecutive cycles, down_src=1 throughout, no bubbles.
3. Fairness: all 4 requesters continuously valid with single-beat packets, data = 16*i+k -> down_src sequence 0,1,2,3,0,1,2,3, each requester's data in order.
4. Packet lock: requester 2 sends a 4-beat packet (last on beat 3) while requester 0 is valid -> down_src=2 for 4 beats, req_ready[0]=0 throughout, then down_src=0.
5. Backpressure: down_ready toggles 1,0,1,0 with 2 requesters streaming 20 beats -> down_data stable while down_valid && !down_ready; scoreboard shows no loss or duplication and 20 beats delivered.
6. Reset mid-packet: assert rst_n low on beat 2 of requester 3's 5-beat packet -> down_valid=0 immediately. After release with requesters 0 and 3 valid -> first grant goes to 0.
